// File: rtl/aes_pkg.sv
// Shared types and constants for the AES key expansion control path.
// Holds the controller state encoding and the round/byte geometry.
// Imported by key_expansion_ctrl; no logic lives here.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        EXPAND = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int          NUM_ROUNDS      = 10;
    localparam int          BYTES_PER_BLOCK = 16;
    localparam logic [7:0]  RCON_EN_ALL     = 8'hFF;
    localparam logic [7:0]  RCON_EN_NONE    = 8'h00;

    // Terminal counter values, sized to the 4-bit byte/round counters.
    localparam logic [3:0]  LAST_BYTE  = 4'(BYTES_PER_BLOCK - 1);
    localparam logic [3:0]  LAST_ROUND = 4'(NUM_ROUNDS - 1);

endpackage

// File: rtl/key_expansion_ctrl.sv
// Purpose: sequences a byte-serial AES-128 key expansion datapath (load 16 key bytes, expand 10 rounds).
// Latency: start sampled at T, LOAD T+1..T+16, EXPAND T+17..T+176, done pulse at T+177.
// Backpressure: none; the datapath consumes one byte per cycle, abort or rst return to IDLE on the next edge.
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   start, abort        - request expansion (IDLE only) / cancel current operation
//   key_req             - external key byte consumed this cycle (LOAD)
//   input_sel, sbox_sel, last_out_sel, bit_out_sel, round_con_enable, round_count
//                       - datapath select lines and round index
//   rk_valid, rk_round  - round-key byte valid and its round number (1..10)
//   busy, done          - LOAD/EXPAND in progress, one-cycle completion pulse
module key_expansion_ctrl
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    output logic       key_req,
    output logic       input_sel,
    output logic       sbox_sel,
    output logic       last_out_sel,
    output logic       bit_out_sel,
    output logic [7:0] round_con_enable,
    output logic [3:0] round_count,
    output logic       rk_valid,
    output logic [3:0] rk_round,
    output logic       busy,
    output logic       done
);

    state_t     state, state_nx;
    logic [3:0] b, b_nx;
    logic [3:0] r, r_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            b     <= 4'd0;
            r     <= 4'd0;
        end else begin
            state <= state_nx;
            b     <= b_nx;
            r     <= r_nx;
        end
    end

    // Next state and counters. Outputs below decode only state/b/r, so
    // start and abort never reach an output combinationally.
    always_comb begin
        state_nx = state;
        b_nx     = b;
        r_nx     = r;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = LOAD;
                    b_nx     = 4'd0;
                    r_nx     = 4'd0;
                end
            end
            LOAD: begin
                b_nx = b + 4'd1;
                if (b == LAST_BYTE) begin
                    state_nx = EXPAND;
                    b_nx     = 4'd0;
                end
            end
            EXPAND: begin
                b_nx = b + 4'd1;
                if (b == LAST_BYTE) begin
                    b_nx = 4'd0;
                    if (r == LAST_ROUND) begin
                        // Clear r rather than let it reach 10.
                        state_nx = DONE;
                        r_nx     = 4'd0;
                    end else begin
                        r_nx = r + 4'd1;
                    end
                end
            end
            DONE: begin
                state_nx = IDLE;
                b_nx     = 4'd0;
                r_nx     = 4'd0;
            end
            default: begin
                state_nx = IDLE;
                b_nx     = 4'd0;
                r_nx     = 4'd0;
            end
        endcase

        // Abort overrides everything in the next-state path, including the
        // round increment at the end of a round.
        if (abort) begin
            state_nx = IDLE;
            b_nx     = 4'd0;
            r_nx     = 4'd0;
        end
    end

    // Output decode; defaults are the idle values.
    always_comb begin
        key_req          = 1'b0;
        input_sel        = 1'b1;
        sbox_sel         = 1'b1;
        last_out_sel     = 1'b0;
        bit_out_sel      = 1'b0;
        round_con_enable = RCON_EN_NONE;
        round_count      = 4'd0;
        rk_valid         = 1'b0;
        rk_round         = 4'd0;
        busy             = 1'b0;
        done             = 1'b0;

        case (state)
            LOAD: begin
                key_req = 1'b1;
                busy    = 1'b1;
            end
            EXPAND: begin
                input_sel   = 1'b0;
                busy        = 1'b1;
                rk_valid    = 1'b1;
                rk_round    = r + 4'd1;
                round_count = r;
                // Bytes 0..3 of each round form the first word: it takes the
                // S-box/rcon term; later words chain with the XOR path.
                last_out_sel = (b < 4'd4);
                bit_out_sel  = (b >= 4'd4);
                // Byte 3 feeds the S-box from the saved rotate byte.
                sbox_sel     = (b != 4'd3);
                round_con_enable = (b == 4'd0) ? RCON_EN_ALL : RCON_EN_NONE;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_key_expansion_ctrl.sv
module tb_key_expansion_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic       key_req;
    logic       input_sel;
    logic       sbox_sel;
    logic       last_out_sel;
    logic       bit_out_sel;
    logic [7:0] round_con_enable;
    logic [3:0] round_count;
    logic       rk_valid;
    logic [3:0] rk_round;
    logic       busy;
    logic       done;

    key_expansion_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .abort            (abort),
        .key_req          (key_req),
        .input_sel        (input_sel),
        .sbox_sel         (sbox_sel),
        .last_out_sel     (last_out_sel),
        .bit_out_sel      (bit_out_sel),
        .round_con_enable (round_con_enable),
        .round_count      (round_count),
        .rk_valid         (rk_valid),
        .rk_round         (rk_round),
        .busy             (busy),
        .done             (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          cyc;
        logic [23:0] vec;
    } exp_t;

    exp_t q[$];

    logic mon_en = 1'b0;
    int   kreq_n = 0;
    int   rkv_n  = 0;
    int   rcon_n = 0;

    // {key_req,input_sel,sbox_sel,last_out_sel,bit_out_sel,rcon[8],round_count[4],rk_valid,rk_round[4],busy,done}
    function automatic logic [23:0] mkvec(input logic kr, input logic is, input logic sb,
                                          input logic lo, input logic bo, input logic [7:0] rc,
                                          input logic [3:0] cnt, input logic v, input logic [3:0] rr,
                                          input logic bz, input logic dn);
        return {kr, is, sb, lo, bo, rc, cnt, v, rr, bz, dn};
    endfunction

    wire [23:0] dut_vec = {key_req, input_sel, sbox_sel, last_out_sel, bit_out_sel,
                           round_con_enable, round_count, rk_valid, rk_round, busy, done};

    logic [23:0] idle_vec;
    logic [23:0] load_vec;
    logic [23:0] done_vec;
    initial begin
        idle_vec = mkvec(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        load_vec = mkvec(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0);
        done_vec = mkvec(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1);
    end

    function automatic logic [23:0] expand_vec(input int rnd, input int byt);
        logic       sb, lo, bo;
        logic [7:0] rc;
        sb = (byt == 3) ? 1'b0 : 1'b1;
        lo = (byt <= 3) ? 1'b1 : 1'b0;
        bo = (byt >= 4) ? 1'b1 : 1'b0;
        rc = (byt == 0) ? 8'hFF : 8'h00;
        return mkvec(1'b0, 1'b0, sb, lo, bo, rc, 4'(rnd), 1'b1, 4'(rnd + 1), 1'b1, 1'b0);
    endfunction

    task automatic check(input string name, input int c, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: actual=%h required=%h", name, c, act, req);
        end
    endtask

    task automatic push(input int c, input logic [23:0] v);
        exp_t e;
        e.cyc = c;
        e.vec = v;
        q.push_back(e);
    endtask

    // Expected schedule for a run whose start is sampled at the end of cycle t.
    task automatic push_run(input int t);
        for (int k = 1; k <= 16; k++) push(t + k, load_vec);
        for (int rn = 0; rn < 10; rn++)
            for (int bt = 0; bt < 16; bt++)
                push(t + 17 + 16 * rn + bt, expand_vec(rn, bt));
        push(t + 177, done_vec);
    endtask

    // Drop expectations from cycle c onward (after abort/reset).
    task automatic trim(input int c);
        while (q.size() > 0 && q[q.size() - 1].cyc >= c) void'(q.pop_back());
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_start();
        start = 1'b1;
        push_run(cyc);
        wait_cyc(1);
        start = 1'b0;
    endtask

    // Monitor: compare every cycle against the scheduled expectation, or the
    // idle values when nothing is scheduled for this cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (key_req) kreq_n++;
            if (rk_valid) rkv_n++;
            if (round_con_enable == 8'hFF) rcon_n++;
            if (q.size() > 0 && q[0].cyc == cyc) begin
                exp_t e;
                e = q.pop_front();
                check("run_outputs", cyc, 32'(dut_vec), 32'(e.vec));
            end else begin
                check("idle_outputs", cyc, 32'(dut_vec), 32'(idle_vec));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog at cycle %0d: actual=running required=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;

        // Reset two cycles, then idle for 20.
        wait_cyc(1);
        mon_en = 1'b1;
        wait_cyc(1);
        rst = 1'b0;
        wait_cyc(20);

        // Full run with event counts.
        kreq_n = 0;
        rkv_n  = 0;
        rcon_n = 0;
        run_start();
        wait_cyc(180);
        check("key_req_cycles", cyc, 32'(kreq_n), 32'd16);
        check("rk_valid_cycles", cyc, 32'(rkv_n), 32'd160);
        check("rcon_ff_cycles", cyc, 32'(rcon_n), 32'd10);

        // Abort while in idle wins over start.
        start = 1'b1;
        abort = 1'b1;
        wait_cyc(1);
        start = 1'b0;
        abort = 1'b0;
        wait_cyc(3);

        // Abort at round 5, byte 7.
        t = cyc;
        run_start();
        wait_cyc(t + 104 - cyc);
        abort = 1'b1;
        trim(cyc + 1);
        wait_cyc(1);
        abort = 1'b0;
        wait_cyc(3);

        // A fresh start after abort runs the full sequence.
        run_start();
        wait_cyc(180);

        // Reset during LOAD at b=9.
        t = cyc;
        run_start();
        wait_cyc(t + 10 - cyc);
        rst = 1'b1;
        trim(cyc + 1);
        wait_cyc(1);
        rst = 1'b0;
        wait_cyc(4);

        // Start held high: back-to-back runs with one idle cycle between.
        t = cyc;
        start = 1'b1;
        push_run(t);
        push_run(t + 178);
        wait_cyc(183);
        start = 1'b0;
        wait_cyc(180);

        check("queue_drained", cyc, 32'(q.size()), 32'd0);
        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
